reg_read_port: RTL and testbench

REG_READ_PORT -- requirements
Module: reg_read_port

---
 rtl/reg_read_port_pkg.sv | 48 ++++
 rtl/reg_sel_mux.sv | 45 ++++
 rtl/reg_read_port.sv | 143 ++++++++++++++
 tb/tb_reg_read_port.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_read_port_pkg.sv
// rtl/reg_read_port_pkg.sv - shared selector codes, FSM state type and write-enable bit map
package reg_read_port_pkg;

    // Read selector codes
    localparam logic [3:0] SEL_AL = 4'd0;
    localparam logic [3:0] SEL_CL = 4'd1;
    localparam logic [3:0] SEL_DL = 4'd2;
    localparam logic [3:0] SEL_BL = 4'd3;
    localparam logic [3:0] SEL_AH = 4'd4;
    localparam logic [3:0] SEL_CH = 4'd5;
    localparam logic [3:0] SEL_DH = 4'd6;
    localparam logic [3:0] SEL_BH = 4'd7;
    localparam logic [3:0] SEL_SP = 4'd8;
    localparam logic [3:0] SEL_BP = 4'd9;
    localparam logic [3:0] SEL_SI = 4'd10;
    localparam logic [3:0] SEL_DI = 4'd11;
    localparam logic [3:0] SEL_AX = 4'd12;
    localparam logic [3:0] SEL_CX = 4'd13;
    localparam logic [3:0] SEL_DX = 4'd14;
    localparam logic [3:0] SEL_BX = 4'd15;

    // Write-enable bit positions on the write bus
    localparam int WE_W  = 12;
    localparam int WE_AL = 11;
    localparam int WE_CL = 10;
    localparam int WE_DL = 9;
    localparam int WE_BL = 8;
    localparam int WE_AH = 7;
    localparam int WE_CH = 6;
    localparam int WE_DH = 5;
    localparam int WE_BH = 4;
    localparam int WE_SP = 3;
    localparam int WE_BP = 2;
    localparam int WE_SI = 1;
    localparam int WE_DI = 0;

    // IDLE: no response held; RESP: response held on the output
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Byte carried by the write bus for an 8-bit register write
    function automatic logic [7:0] wr_byte(input logic [15:0] data, input logic sel_hi);
        return sel_hi ? data[15:8] : data[7:0];
    endfunction

endpackage

// File: rtl/reg_sel_mux.sv
// rtl/reg_sel_mux.sv - combinational 16-way register selector with zero-extension of byte registers
module reg_sel_mux
    import reg_read_port_pkg::*;
(
    input  logic [7:0]  al_i,
    input  logic [7:0]  cl_i,
    input  logic [7:0]  dl_i,
    input  logic [7:0]  bl_i,
    input  logic [7:0]  ah_i,
    input  logic [7:0]  ch_i,
    input  logic [7:0]  dh_i,
    input  logic [7:0]  bh_i,
    input  logic [15:0] sp_i,
    input  logic [15:0] bp_i,
    input  logic [15:0] si_i,
    input  logic [15:0] di_i,
    input  logic [3:0]  sel_i,
    output logic [15:0] data_o
);

    // Pick the addressed register; byte registers are zero-extended, pairs are {high, low}
    always_comb begin
        data_o = 16'h0000;
        case (sel_i)
            SEL_AL:  data_o = {8'h00, al_i};
            SEL_CL:  data_o = {8'h00, cl_i};
            SEL_DL:  data_o = {8'h00, dl_i};
            SEL_BL:  data_o = {8'h00, bl_i};
            SEL_AH:  data_o = {8'h00, ah_i};
            SEL_CH:  data_o = {8'h00, ch_i};
            SEL_DH:  data_o = {8'h00, dh_i};
            SEL_BH:  data_o = {8'h00, bh_i};
            SEL_SP:  data_o = sp_i;
            SEL_BP:  data_o = bp_i;
            SEL_SI:  data_o = si_i;
            SEL_DI:  data_o = di_i;
            SEL_AX:  data_o = {ah_i, al_i};
            SEL_CX:  data_o = {ch_i, cl_i};
            SEL_DX:  data_o = {dh_i, dl_i};
            SEL_BX:  data_o = {bh_i, bl_i};
            default: data_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - valid/ready register read port with one-deep response register (REG_READ_BYPASS_EN enables write forwarding)
module reg_read_port
    import reg_read_port_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       AL,
    input  logic [7:0]       CL,
    input  logic [7:0]       DL,
    input  logic [7:0]       BL,
    input  logic [7:0]       AH,
    input  logic [7:0]       CH,
    input  logic [7:0]       DH,
    input  logic [7:0]       BH,
    input  logic [15:0]      SP,
    input  logic [15:0]      BP,
    input  logic [15:0]      SI,
    input  logic [15:0]      DI,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [3:0]       REQ_SEL,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [15:0]      RSP_DATA,
    input  logic [WE_W-1:0]  WR_WE,
    input  logic             WR_SEL,
    input  logic [15:0]      WR_DATA,
    output logic [CNT_W-1:0] RD_CNT
);

    state_e            state_q, state_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

    logic [7:0]        al_f, cl_f, dl_f, bl_f, ah_f, ch_f, dh_f, bh_f;
    logic [15:0]       sp_f, bp_f, si_f, di_f;
    logic [15:0]       sel_data;
    logic              accept;
    logic              rsp_fire;

`ifdef REG_READ_BYPASS_EN
    // A write landing in the acceptance cycle wins over the stale register value;
    // pairs pick up each byte independently because they read the forwarded bytes.
    logic [7:0] wr_b;
    assign wr_b = wr_byte(WR_DATA, WR_SEL);
    assign al_f = WR_WE[WE_AL] ? wr_b : AL;
    assign cl_f = WR_WE[WE_CL] ? wr_b : CL;
    assign dl_f = WR_WE[WE_DL] ? wr_b : DL;
    assign bl_f = WR_WE[WE_BL] ? wr_b : BL;
    assign ah_f = WR_WE[WE_AH] ? wr_b : AH;
    assign ch_f = WR_WE[WE_CH] ? wr_b : CH;
    assign dh_f = WR_WE[WE_DH] ? wr_b : DH;
    assign bh_f = WR_WE[WE_BH] ? wr_b : BH;
    assign sp_f = WR_WE[WE_SP] ? WR_DATA : SP;
    assign bp_f = WR_WE[WE_BP] ? WR_DATA : BP;
    assign si_f = WR_WE[WE_SI] ? WR_DATA : SI;
    assign di_f = WR_WE[WE_DI] ? WR_DATA : DI;
`else
    // Without forwarding the write bus has no effect on reads
    logic unused_wr;
    assign unused_wr = ^{WR_WE, WR_SEL, WR_DATA};
    assign al_f = AL;
    assign cl_f = CL;
    assign dl_f = DL;
    assign bl_f = BL;
    assign ah_f = AH;
    assign ch_f = CH;
    assign dh_f = DH;
    assign bh_f = BH;
    assign sp_f = SP;
    assign bp_f = BP;
    assign si_f = SI;
    assign di_f = DI;
`endif

    reg_sel_mux u_sel_mux (
        .al_i   (al_f),
        .cl_i   (cl_f),
        .dl_i   (dl_f),
        .bl_i   (bl_f),
        .ah_i   (ah_f),
        .ch_i   (ch_f),
        .dh_i   (dh_f),
        .bh_i   (bh_f),
        .sp_i   (sp_f),
        .bp_i   (bp_f),
        .si_i   (si_f),
        .di_i   (di_f),
        .sel_i  (REQ_SEL),
        .data_o (sel_data)
    );

    // A new request fits whenever the slot is empty or is being drained this cycle
    assign REQ_READY = (state_q == ST_IDLE) | RSP_READY;
    assign RSP_VALID = (state_q == ST_RESP);
    assign RSP_DATA  = rsp_data_q;
    assign RD_CNT    = rd_cnt_q;

    assign accept    = REQ_VALID & REQ_READY;
    assign rsp_fire  = RSP_VALID & RSP_READY;

    // Next state, response capture and completion count
    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rd_cnt_d   = rd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    state_d = accept ? ST_RESP : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            rsp_data_d = sel_data;
        end
        if (rsp_fire) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops any held response and clears the count
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            rsp_data_q <= 16'h0000;
            rd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_read_port.sv
// tb/tb_reg_read_port.sv - self-checking bench for reg_read_port (honours REG_READ_BYPASS_EN)
module tb_reg_read_port;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  AL, CL, DL, BL, AH, CH, DH, BH;
    logic [15:0] SP, BP, SI, DI;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [3:0]  REQ_SEL;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [15:0] RSP_DATA;
    logic [11:0] WR_WE;
    logic        WR_SEL;
    logic [15:0] WR_DATA;
    logic [7:0]  RD_CNT;

    int tests = 0;
    int fails = 0;
    int fires = 0;

    bit          m_hold;
    logic [15:0] m_data;
    int          m_cnt;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[16];

    reg_read_port #(.CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .AL(AL), .CL(CL), .DL(DL), .BL(BL), .AH(AH), .CH(CH), .DH(DH), .BH(BH),
        .SP(SP), .BP(BP), .SI(SI), .DI(DI),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_SEL(REQ_SEL),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .WR_WE(WR_WE), .WR_SEL(WR_SEL), .WR_DATA(WR_DATA),
        .RD_CNT(RD_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value a read of sel should return, from the register file viewed as arrays
    function automatic logic [15:0] model_value(input logic [3:0] sel);
        logic [7:0]  b[8];
        logic [15:0] w[4];
        int s;
        b = '{AL, CL, DL, BL, AH, CH, DH, BH};
        w = '{SP, BP, SI, DI};
`ifdef REG_READ_BYPASS_EN
        for (int i = 0; i < 8; i++)
            if (WR_WE[11-i]) b[i] = WR_SEL ? WR_DATA[15:8] : WR_DATA[7:0];
        for (int j = 0; j < 4; j++)
            if (WR_WE[3-j]) w[j] = WR_DATA;
`endif
        s = int'(sel);
        if (s < 8)       return {8'h00, b[s]};
        else if (s < 12) return w[s-8];
        else             return {b[s-8], b[s-12]};
    endfunction

    // One clock: check ready before the edge, advance the model, check outputs after it
    task automatic step();
        bit          acc;
        logic [15:0] v;
        #1;
        if (RST) chk("req_ready", REQ_READY, (!m_hold || RSP_READY));
        if (RSP_VALID && RSP_READY) fires++;
        acc = REQ_VALID && (!m_hold || RSP_READY);
        v   = model_value(REQ_SEL);
        @(posedge CLK);
        if (!RST) begin
            m_hold = 0;
            m_data = 16'h0000;
            m_cnt  = 0;
        end else begin
            if (m_hold && RSP_READY) begin
                m_cnt++;
                m_hold = 0;
            end
            if (acc) begin
                m_hold = 1;
                m_data = v;
            end
        end
        #1;
        chk("rsp_valid", RSP_VALID, m_hold);
        chk("rd_cnt", RD_CNT, m_cnt & 255);
        if (m_hold || !RST) chk("rsp_data", RSP_DATA, m_data);
    endtask

    task automatic cyc(input logic v, input logic [3:0] s, input logic rr);
        @(negedge CLK);
        REQ_VALID = v;
        REQ_SEL   = s;
        RSP_READY = rr;
        step();
    endtask

    task automatic do_reset();
        RST = 1'b0;
        cyc(1'b1, 4'd0, 1'b1);
        RST = 1'b1;
    endtask

    initial begin
        int cnt_before;
        RST = 1'b0; REQ_VALID = 0; REQ_SEL = 0; RSP_READY = 0;
        AL = 0; CL = 0; DL = 0; BL = 0; AH = 0; CH = 0; DH = 0; BH = 0;
        SP = 0; BP = 0; SI = 0; DI = 0;
        WR_WE = 0; WR_SEL = 0; WR_DATA = 0;
        m_hold = 0; m_data = 0; m_cnt = 0;

        // Reset, with a request offered during reset that must not produce a response
        cyc(1'b1, 4'd0, 1'b0);
        cyc(1'b1, 4'd0, 1'b0);
        chk("reset_valid", RSP_VALID, 1'b0);
        chk("reset_data", RSP_DATA, 16'h0000);
        chk("reset_cnt", RD_CNT, 8'd0);
        RST = 1'b1;
        @(negedge CLK);
        REQ_VALID = 0; RSP_READY = 0;
        #1 chk("ready_after_reset", REQ_READY, 1'b1);

        // Single read of AL
        AL = 8'h5A;
        cyc(1'b1, 4'd0, 1'b0);
        chk("al_valid", RSP_VALID, 1'b1);
        chk("al_data", RSP_DATA, 16'h005A);

        // Table of all selectors against a fixed register pattern, back-to-back
        AL = 8'h01; CL = 8'h23; DL = 8'h45; BL = 8'h67;
        AH = 8'h89; CH = 8'hAB; DH = 8'hCD; BH = 8'hEF;
        SP = 16'hA55A; BP = 16'h0FF0; SI = 16'h1234; DI = 16'hFEDC;
        vecs = '{'{4'd0, 16'h0001}, '{4'd1, 16'h0023}, '{4'd2, 16'h0045}, '{4'd3, 16'h0067},
                 '{4'd4, 16'h0089}, '{4'd5, 16'h00AB}, '{4'd6, 16'h00CD}, '{4'd7, 16'h00EF},
                 '{4'd8, 16'hA55A}, '{4'd9, 16'h0FF0}, '{4'd10, 16'h1234}, '{4'd11, 16'hFEDC},
                 '{4'd12, 16'h8901}, '{4'd13, 16'hAB23}, '{4'd14, 16'hCD45}, '{4'd15, 16'hEF67}};
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, vecs[i].sel, 1'b1);
            chk($sformatf("vec%0d_valid", i), RSP_VALID, 1'b1);
            chk($sformatf("vec%0d_data", i), RSP_DATA, vecs[i].exp);
        end
        cyc(1'b0, 4'd0, 1'b1);
        chk("drain_valid", RSP_VALID, 1'b0);

        // AX pair and SP
        AH = 8'h12; AL = 8'h34;
        cyc(1'b1, 4'd12, 1'b1);
        chk("ax_data", RSP_DATA, 16'h1234);
        SP = 16'hBEEF;
        cyc(1'b1, 4'd8, 1'b1);
        chk("sp_data", RSP_DATA, 16'hBEEF);

        // Back-pressure: response holds while DI moves, then a new read replaces it
        DI = 16'h1357;
        cyc(1'b1, 4'd11, 1'b1);
        for (int i = 0; i < 5; i++) begin
            DI = 16'($urandom);
            cyc(1'b1, 4'd11, 1'b0);
            chk("hold_data", RSP_DATA, 16'h1357);
            chk("hold_ready", REQ_READY, 1'b0);
        end
        cnt_before = m_cnt;
        DI = 16'h2468;
        cyc(1'b1, 4'd11, 1'b1);
        chk("release_data", RSP_DATA, 16'h2468);
        chk("release_cnt", RD_CNT, (cnt_before + 1) & 255);
        cyc(1'b0, 4'd0, 1'b1);

        // Write forwarding on CL (high byte of write bus) and byte-wise on AX
        CL = 8'h00; WR_WE = 12'h400; WR_SEL = 1'b1; WR_DATA = 16'hAB00;
        cyc(1'b1, 4'd1, 1'b1);
`ifdef REG_READ_BYPASS_EN
        chk("bypass_cl", RSP_DATA, 16'h00AB);
`else
        chk("bypass_cl", RSP_DATA, 16'h0000);
`endif
        AH = 8'h11; AL = 8'h22; WR_WE = 12'h080; WR_SEL = 1'b0; WR_DATA = 16'h3344;
        cyc(1'b1, 4'd12, 1'b1);
`ifdef REG_READ_BYPASS_EN
        chk("bypass_ax", RSP_DATA, 16'h4422);
`else
        chk("bypass_ax", RSP_DATA, 16'h1122);
`endif
        WR_WE = 12'h000;
        cyc(1'b0, 4'd0, 1'b1);

        // Reset while a response is held
        cyc(1'b1, 4'd3, 1'b0);
        chk("pre_reset_valid", RSP_VALID, 1'b1);
        RST = 1'b0;
        cyc(1'b1, 4'd5, 1'b1);
        chk("mid_reset_valid", RSP_VALID, 1'b0);
        chk("mid_reset_data", RSP_DATA, 16'h0000);
        chk("mid_reset_cnt", RD_CNT, 8'd0);
        RST = 1'b1;

        // 300 back-to-back reads; counter wraps to 44
        do_reset();
        fires = 0;
        for (int i = 0; i < 300; i++) begin
            {AL, CL, DL, BL} = $urandom;
            {AH, CH, DH, BH} = $urandom;
            {SP, BP} = $urandom;
            {SI, DI} = $urandom;
            cyc(1'b1, 4'($urandom_range(0, 15)), 1'b1);
        end
        cyc(1'b0, 4'd0, 1'b1);
        chk("stream_fires", fires, 300);
        chk("stream_cnt", RD_CNT, 8'd44);

        // Random traffic with occasional resets and write-bus activity
        for (int i = 0; i < 1500; i++) begin
            {AL, CL, DL, BL} = $urandom;
            {AH, CH, DH, BH} = $urandom;
            {SP, BP} = $urandom;
            {SI, DI} = $urandom;
            WR_WE   = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'h000;
            WR_SEL  = 1'($urandom);
            WR_DATA = 16'($urandom);
            RST     = ($urandom_range(0, 99) != 0);
            cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
        end
        RST = 1'b1;
        WR_WE = 12'h000;
        cyc(1'b0, 4'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
